// File: rtl/bram_stream_reader_pkg.sv
// Shared constants and helpers for the BRAM stream reader and its response FIFO.
// Default widths match the BRAMLike wrapper so both sides agree without overrides.
package bram_stream_reader_pkg;

    localparam int DATA_WIDTH_DEF    = 16;
    localparam int ADDR_WIDTH_DEF    = 11;
    localparam int BUF_DEPTH_MIN     = 2;
    localparam int BUF_DEPTH_MAX     = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= BUF_DEPTH_MIN) && (depth <= BUF_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Request/response stream bundle plus the BRAM read-port pair seen by the reader.
// The slave modport is the reader's view; master is the surrounding system's view.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 11
);
    logic                     req_valid;
    logic                     req_ready;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [ADDRESS_WIDTH-1:0] mem_raddr;
    logic [DATA_WIDTH-1:0]    mem_dout;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [DATA_WIDTH-1:0]    resp_data;

    modport slave (
        input  req_valid, req_addr, mem_dout, resp_ready,
        output req_ready, mem_raddr, resp_valid, resp_data
    );

    modport master (
        output req_valid, req_addr, mem_dout, resp_ready,
        input  req_ready, mem_raddr, resp_valid, resp_data
    );
endinterface

// File: rtl/bram_stream_reader_stream_fifo.sv
// Register FIFO holding captured BRAM words until downstream takes them.
// Depth need not be a power of two; pointers wrap explicitly at BUFFER_DEPTH-1.
module stream_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int BUFFER_DEPTH = 3,
    localparam int PTR_W       = clog2(BUFFER_DEPTH),
    localparam int CNT_W       = clog2(BUFFER_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0]      count_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_i && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!push_i && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the output mux hides stale entries when empty.
    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Wraps a 1-cycle-latency BRAM read port in valid/ready request and response streams.
// Credits reserve a buffer slot at acceptance, so the unstallable BRAM return always fits.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int ADDRESS_WIDTH = ADDR_WIDTH_DEF,
    parameter int BUFFER_DEPTH  = 3,
    localparam int CNT_W        = clog2(BUFFER_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    bram_stream_reader_if.slave  bus
);

    if (!depth_ok(BUFFER_DEPTH)) begin : g_bad_depth
        $error("bram_stream_reader: BUFFER_DEPTH must be within 2..8");
    end

    logic                     inflight_q, inflight_d;
    logic                     accept;
    logic                     pop;
    logic [CNT_W-1:0]         count;
    logic [CNT_W:0]           credit_used;
    logic [ADDRESS_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0]    fifo_dout;

    // The BRAM registers the address itself; unaccepted reads are simply never captured.
    assign raddr         = bus.req_addr;
    assign bus.mem_raddr = raddr;

    assign credit_used   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    assign bus.req_ready = credit_used < (CNT_W + 1)'(BUFFER_DEPTH);
    assign accept        = bus.req_valid && bus.req_ready;
    assign inflight_d    = accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign bus.resp_valid = (count != '0);
    assign pop            = bus.resp_valid && bus.resp_ready;
    assign bus.resp_data  = fifo_dout;

    stream_fifo #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BUFFER_DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (inflight_q),
        .din_i   (bus.mem_dout),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (count)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and scoreboarded checks of the BRAM stream reader at depths 3 and 2.
module tb_bram_stream_reader;
    import bram_stream_reader_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bram_stream_reader_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(11)) bus3 ();
    bram_stream_reader_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(11)) bus2 ();

    bram_stream_reader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(11), .BUFFER_DEPTH(3)) u_dut3 (
        .clock (clock), .reset (reset), .bus (bus3)
    );
    bram_stream_reader #(.DATA_WIDTH(16), .ADDRESS_WIDTH(11), .BUFFER_DEPTH(2)) u_dut2 (
        .clock (clock), .reset (reset), .bus (bus2)
    );

    logic [15:0] mem [2048];
    always @(posedge clock) begin
        bus3.mem_dout <= mem[bus3.mem_raddr];
        bus2.mem_dout <= mem[bus2.mem_raddr];
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic phase3(input logic rv, input logic [10:0] ra, input logic rr);
        @(negedge clock);
        bus3.req_valid  = rv;
        bus3.req_addr   = ra;
        bus3.resp_ready = rr;
        #1;
    endtask

    task automatic phase2(input logic rv, input logic [10:0] ra, input logic rr);
        @(negedge clock);
        bus2.req_valid  = rv;
        bus2.req_addr   = ra;
        bus2.resp_ready = rr;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus3.req_valid = 1'b0; bus3.resp_ready = 1'b0; bus3.req_addr = '0;
        bus2.req_valid = 1'b0; bus2.resp_ready = 1'b0; bus2.req_addr = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] q3[$];
        logic [15:0] q2[$];
        int first, last, got, drops, idx, rcv, acc, outst, maxout, stale, run, maxrun;
        logic rv, rr;
        logic [10:0] ra;

        for (int i = 0; i < 2048; i++) mem[i] = 16'(i) ^ 16'h5A5A;
        reset = 1'b1;
        bus3.req_valid = 1'b0; bus3.resp_ready = 1'b0; bus3.req_addr = '0;
        bus2.req_valid = 1'b0; bus2.resp_ready = 1'b0; bus2.req_addr = '0;
        #1;
        check_vec("rst_req_ready",  bus3.req_ready,  1);
        check_vec("rst_resp_valid", bus3.resp_valid, 0);
        check_vec("rst_resp_data",  bus3.resp_data,  0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_vec("idle_req_ready",  bus3.req_ready,  1);
        check_vec("idle_resp_valid", bus3.resp_valid, 0);
        check_vec("idle_d2_ready",   bus2.req_ready,  1);

        // Single read: accept at N, nothing at N+1, data at N+2.
        mem[5] = 16'hBEEF;
        phase3(1'b1, 11'h005, 1'b1);
        check_vec("single_accept", bus3.req_ready, 1);
        phase3(1'b0, 11'h000, 1'b1);
        check_vec("single_n1_valid", bus3.resp_valid, 0);
        phase3(1'b0, 11'h000, 1'b1);
        check_vec("single_n2_valid", bus3.resp_valid, 1);
        check_vec("single_n2_data",  bus3.resp_data,  16'hBEEF);
        phase3(1'b0, 11'h000, 1'b1);
        check_vec("single_after_pop", bus3.resp_valid, 0);
        mem[5] = 16'h0005 ^ 16'h5A5A;

        // Reset with buffered and in-flight reads pending.
        phase3(1'b1, 11'd40, 1'b0);
        phase3(1'b1, 11'd41, 1'b0);
        do_reset();
        check_vec("midrst_req_ready",  bus3.req_ready,  1);
        check_vec("midrst_resp_valid", bus3.resp_valid, 0);
        check_vec("midrst_resp_data",  bus3.resp_data,  0);
        stale = 0;
        for (int p = 0; p < 6; p++) begin
            phase3(1'b0, 11'd0, 1'b1);
            if (bus3.resp_valid) stale++;
        end
        check_vec("midrst_stale", stale, 0);

        // Streaming 100 back-to-back reads at depth 3.
        first = -1; last = -1; got = 0; drops = 0;
        for (int p = 0; p < 130; p++) begin
            phase3(p < 100, 11'(p), 1'b1);
            if (p < 100 && !bus3.req_ready) drops++;
            if (bus3.resp_valid) begin
                if (first < 0) first = p;
                last = p;
                if (got < 100) check_vec("stream_data", bus3.resp_data, mem[got]);
                got++;
            end
        end
        check_vec("stream_drops", drops, 0);
        check_vec("stream_count", got, 100);
        check_vec("stream_first", first, 2);
        check_vec("stream_span",  last - first, 99);

        // Backpressure: only three credits, head word held while stalled.
        idx = 0;
        for (int p = 0; p < 8; p++) begin
            phase3(1'b1, 11'(20 + idx), 1'b0);
            if (bus3.req_ready) idx++;
            if (bus3.resp_valid) check_vec("bp_hold", bus3.resp_data, mem[20]);
        end
        check_vec("bp_accepted",   idx, 3);
        check_vec("bp_req_ready",  bus3.req_ready, 0);
        check_vec("bp_resp_valid", bus3.resp_valid, 1);
        check_vec("bp_head",       bus3.resp_data, mem[20]);
        rcv = 0;
        for (int p = 0; p < 30 && rcv < 5; p++) begin
            phase3(idx < 5, 11'(20 + idx), 1'b1);
            if (idx < 5 && bus3.req_ready) idx++;
            if (bus3.resp_valid) begin
                check_vec("bp_drain", bus3.resp_data, mem[20 + rcv]);
                rcv++;
            end
        end
        check_vec("bp_rcv", rcv, 5);
        check_vec("bp_all_accepted", idx, 5);

        // Random traffic against a scoreboard, exercising pointer wrap.
        acc = 0; outst = 0; maxout = 0;
        for (int p = 0; p < 60000 && acc < 10000; p++) begin
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 3) != 0);
            ra = 11'($urandom_range(0, 2047));
            phase3(rv, ra, rr);
            if (rv && bus3.req_ready) begin
                q3.push_back(mem[ra]);
                acc++;
                outst++;
            end
            if (bus3.resp_valid && rr) begin
                if (q3.size() == 0) check_vec("wrap_spurious", 1, 0);
                else check_vec("wrap_data", bus3.resp_data, q3.pop_front());
                outst--;
            end
            if (outst > maxout) maxout = outst;
        end
        for (int p = 0; p < 20 && q3.size() > 0; p++) begin
            phase3(1'b0, 11'd0, 1'b1);
            if (bus3.resp_valid) check_vec("wrap_drain", bus3.resp_data, q3.pop_front());
        end
        check_vec("wrap_accepted", acc, 10000);
        check_vec("wrap_left",     q3.size(), 0);
        check_vec("wrap_max_outstanding_le3", maxout <= 3, 1);

        // Depth 2: continuous requests, throttled but lossless.
        acc = 0; outst = 0; maxout = 0; run = 0; maxrun = 0;
        for (int p = 0; p < 30; p++) begin
            phase2(1'b1, 11'(200 + acc), 1'b1);
            if (bus2.req_ready) begin
                q2.push_back(mem[200 + acc]);
                acc++;
                outst++;
                run++;
            end else begin
                run = 0;
            end
            if (run > maxrun) maxrun = run;
            if (bus2.resp_valid) begin
                if (q2.size() == 0) check_vec("d2_spurious", 1, 0);
                else check_vec("d2_data", bus2.resp_data, q2.pop_front());
                outst--;
            end
            if (outst > maxout) maxout = outst;
        end
        for (int p = 0; p < 10 && q2.size() > 0; p++) begin
            phase2(1'b0, 11'd0, 1'b1);
            if (bus2.resp_valid) check_vec("d2_drain", bus2.resp_data, q2.pop_front());
        end
        check_vec("d2_rate_min",  acc >= 15, 1);
        check_vec("d2_throttled", acc < 30, 1);
        check_vec("d2_max_run",   maxrun <= 2, 1);
        check_vec("d2_max_outstanding_le2", maxout <= 2, 1);
        check_vec("d2_left",      q2.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
